// File: rtl/filter_arbiter.sv
`timescale 1ns/1ps
// filter_arbiter: round-robin sharing of one packet_filter between NUM_PORTS ingress byte streams.
// Define FILTER_ARB_STATS_EN to build the saturating allowed/blocked verdict counters.
module filter_arbiter #(
  parameter int NUM_PORTS = 4,
  parameter int PKT_LEN   = 40,
  parameter int TIMEOUT   = 64,
  parameter int PORT_W    = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_PORTS-1:0]   req,
  input  logic [8*NUM_PORTS-1:0] port_data,
  input  logic [NUM_PORTS-1:0]   port_valid,
  output logic [NUM_PORTS-1:0]   grant,
  output logic                   flt_rst,
  output logic [7:0]             flt_data,
  output logic                   flt_valid,
  input  logic                   flt_allowed,
  input  logic                   flt_done,
  output logic                   verdict_valid,
  output logic                   verdict_allowed,
  output logic [PORT_W-1:0]      verdict_port,
  output logic                   verdict_timeout,
  output logic                   busy,
  output logic [15:0]            allowed_count,
  output logic [15:0]            blocked_count
);

  localparam int unsigned NP    = NUM_PORTS;
  localparam int          CNT_W = $clog2(PKT_LEN + 1);
  localparam int          TMO_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, CLEAR, STREAM, WAIT, REPORT} state_t;

  state_t            state_q, state_d;
  logic [PORT_W-1:0] sel_q, last_q, pick, cand;
  logic              found;
  logic [CNT_W-1:0]  byte_cnt_q;
  logic [TMO_W-1:0]  tmo_cnt_q;
  logic              done_q, allowed_q;
  logic              flt_rst_q, flt_valid_q;
  logic [7:0]        flt_data_q;
  logic [7:0]        sel_data;
  logic              sel_valid;

  always_comb begin
    sel_data  = port_data[8*sel_q +: 8];
    sel_valid = port_valid[sel_q];
  end

  // Search upward from last+1 with wrap-around; first requester wins.
  always_comb begin
    pick  = last_q;
    found = 1'b0;
    cand  = '0;
    for (int unsigned i = 1; i <= NP; i++) begin
      cand = PORT_W'((32'(last_q) + i) % NP);
      if (!found && req[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (found) state_d = CLEAR;
      CLEAR:   state_d = STREAM;
      STREAM:  if (sel_valid && byte_cnt_q == CNT_W'(PKT_LEN - 1)) state_d = WAIT;
      WAIT: begin
        if (done_q)                              state_d = REPORT;
        else if (tmo_cnt_q == TMO_W'(TIMEOUT))   state_d = REPORT;
      end
      REPORT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      sel_q       <= '0;
      last_q      <= PORT_W'(NUM_PORTS - 1);
      byte_cnt_q  <= '0;
      tmo_cnt_q   <= '0;
      done_q      <= 1'b0;
      allowed_q   <= 1'b0;
      flt_rst_q   <= 1'b1;
      flt_valid_q <= 1'b0;
      flt_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      flt_rst_q   <= (state_d == CLEAR);
      flt_valid_q <= 1'b0;
      flt_data_q  <= '0;
      case (state_q)
        IDLE: if (found) sel_q <= pick;
        CLEAR: begin
          byte_cnt_q <= '0;
          tmo_cnt_q  <= '0;
          done_q     <= 1'b0;
          allowed_q  <= 1'b0;
        end
        STREAM: begin
          flt_data_q  <= sel_data;
          flt_valid_q <= sel_valid;
          if (sel_valid) byte_cnt_q <= byte_cnt_q + 1'b1;
          if (!done_q && flt_done) begin
            done_q    <= 1'b1;
            allowed_q <= flt_allowed;
          end
        end
        WAIT: begin
          tmo_cnt_q <= tmo_cnt_q + 1'b1;
          // A done arriving on the timeout cycle is too late; the verdict stays fail-closed.
          if (state_d == WAIT && !done_q && flt_done) begin
            done_q    <= 1'b1;
            allowed_q <= flt_allowed;
          end
        end
        REPORT: last_q <= sel_q;
        default: ;
      endcase
    end
  end

  always_comb begin
    busy            = (state_q != IDLE);
    grant           = busy ? (NUM_PORTS'(1) << sel_q) : '0;
    flt_rst         = flt_rst_q;
    flt_data        = flt_data_q;
    flt_valid       = flt_valid_q;
    verdict_valid   = (state_q == REPORT);
    verdict_port    = verdict_valid ? sel_q : '0;
    verdict_allowed = verdict_valid & done_q & allowed_q;
    verdict_timeout = verdict_valid & ~done_q;
  end

`ifdef FILTER_ARB_STATS_EN
  logic [15:0] allowed_cnt_q, blocked_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      allowed_cnt_q <= '0;
      blocked_cnt_q <= '0;
    end else if (verdict_valid) begin
      if (verdict_allowed) begin
        if (allowed_cnt_q != '1) allowed_cnt_q <= allowed_cnt_q + 1'b1;
      end else begin
        if (blocked_cnt_q != '1) blocked_cnt_q <= blocked_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    allowed_count = allowed_cnt_q;
    blocked_count = blocked_cnt_q;
  end
`else
  always_comb begin
    allowed_count = '0;
    blocked_count = '0;
  end
`endif

endmodule
